// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side initiator for one 32-bit ALU.
// Accepts requests over valid/ready, drives the ALU inputs from registers,
// and returns the captured result/zero over a held valid/ready response.
// Opcode 15 is a multiply made from MUL_ITER repeated ALU ADDs (shift-and-add).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | req_ready_o=1, ALU inputs at 0, waiting for a request
// EXEC  | one ALU cycle for a single-cycle code, result captured at its end
// MUL   | one shift-and-add iteration per cycle, ALU held at ADD
// RESP  | rsp_valid_o=1, result/zero held until rsp_ready_i
module alu_sequencer #(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_op_i,
  input  logic [DATA_W-1:0] req_a_i,
  input  logic [DATA_W-1:0] req_b_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o
);

  localparam int            CNT_W    = $clog2(MUL_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);
  localparam logic [3:0]    OP_ADD   = 4'd2;
  localparam logic [3:0]    OP_MUL   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_result;
  logic                r_rsp_zero;
  logic [DATA_W-1:0]   r_alu_src1;
  logic [DATA_W-1:0]   r_alu_src2;
  logic [3:0]          r_alu_ctrl;
  // r_mcand already holds the multiplicand shifted for the NEXT iteration and
  // r_mplier holds the multiplier bits not yet consumed, so the addend for the
  // next cycle can be registered directly from them.
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_count;

  logic [DATA_W-1:0]   w_next_addend;

  // Addend for the following multiply iteration: shifted multiplicand if the
  // next multiplier bit is set.
  always_comb begin
    w_next_addend = r_mplier[0] ? r_mcand : '0;
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_alu_src1   <= '0;
      r_alu_src2   <= '0;
      r_alu_ctrl   <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i && r_req_ready) begin
            r_req_ready <= 1'b0;
            if (req_op_i == OP_MUL) begin
              // Iteration 0 operands: acc=0, addend = B[0] ? A : 0.
              r_state    <= ST_MUL;
              r_alu_ctrl <= OP_ADD;
              r_alu_src1 <= '0;
              r_alu_src2 <= req_b_i[0] ? req_a_i : '0;
              r_mcand    <= req_a_i << 1;
              r_mplier   <= req_b_i >> 1;
              r_count    <= '0;
            end else begin
              // Unsupported codes are forwarded as-is; the ALU answers 0.
              r_state    <= ST_EXEC;
              r_alu_ctrl <= req_op_i;
              r_alu_src1 <= req_a_i;
              r_alu_src2 <= req_b_i;
            end
          end
        end

        ST_EXEC: begin
          r_rsp_result <= alu_result_i;
          r_rsp_zero   <= alu_zero_i;
          r_rsp_valid  <= 1'b1;
          r_alu_src1   <= '0;
          r_alu_src2   <= '0;
          r_alu_ctrl   <= '0;
          r_state      <= ST_RESP;
        end

        ST_MUL: begin
          if (r_count == CNT_LAST) begin
            // Final partial sum is the low word of A*B; ALU zero is ignored.
            r_rsp_result <= alu_result_i;
            r_rsp_zero   <= (alu_result_i == '0);
            r_rsp_valid  <= 1'b1;
            r_alu_src1   <= '0;
            r_alu_src2   <= '0;
            r_alu_ctrl   <= '0;
            r_state      <= ST_RESP;
          end else begin
            r_alu_src1 <= alu_result_i;
            r_alu_src2 <= w_next_addend;
            r_mcand    <= r_mcand << 1;
            r_mplier   <= r_mplier >> 1;
            r_count    <= r_count + 1'b1;
          end
        end

        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_alu_src1  <= '0;
          r_alu_src2  <= '0;
          r_alu_ctrl  <= '0;
        end
      endcase
    end
  end

  assign req_ready_o  = r_req_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_result_o = r_rsp_result;
  assign rsp_zero_o   = r_rsp_zero;
  assign alu_src1_o   = r_alu_src1;
  assign alu_src2_o   = r_alu_src2;
  assign alu_ctrl_o   = r_alu_ctrl;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU attached to the ALU port,
// expected results from plain arithmetic on the request operands.
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  int errors = 0;
  int checks = 0;

  alu_sequencer #(.DATA_W(32), .MUL_ITER(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .alu_src1_o  (alu_src1),
    .alu_src2_o  (alu_src2),
    .alu_ctrl_o  (alu_ctrl),
    .alu_result_i(alu_result),
    .alu_zero_i  (alu_zero),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_result_o(rsp_result),
    .rsp_zero_o  (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'd0:  alu_result = alu_src1 & alu_src2;
      4'd1:  alu_result = alu_src1 | alu_src2;
      4'd2:  alu_result = alu_src1 + alu_src2;
      4'd6:  alu_result = alu_src1 - alu_src2;
      4'd7:  alu_result = (alu_src1 < alu_src2) ? 32'd1 : 32'd0;
      4'd8:  alu_result = alu_src1 >> alu_src2;
      4'd9:  alu_result = alu_src2 << 16;
      4'd10: alu_result = alu_src1 - alu_src2;
      4'd12: alu_result = ~(alu_src1 | alu_src2);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_ctrl == 4'd10) ? (alu_result != 0) : (alu_result == 0);
  end

  // Reference: what the sequencer must answer for a request
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z);
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd6:  r = a - b;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = a >> b;
      4'd9:  r = b << 16;
      4'd10: r = a - b;
      4'd12: r = ~(a | b);
      4'd15: r = a * b;
      default: r = 32'd0;
    endcase
    z = (op == 4'd10) ? (r != 0) : (r == 0);
  endtask

  // Present a request, wait for its acceptance and for the response.
  // lat = clock edges from the accepting edge until rsp_valid is seen;
  // ctrl_bad = cycles in between where alu_ctrl was not ADD.
  task automatic do_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int ctrl_bad, output logic tmo);
    int w;
    lat = 0; ctrl_bad = 0; tmo = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    w = 0;
    while (!req_ready && w < 100) begin @(negedge clk); w++; end
    if (!req_ready) begin tmo = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_a = $urandom; req_b = $urandom;
    while (!rsp_valid && lat < 200) begin
      if (alu_ctrl !== 4'd2) ctrl_bad++;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) tmo = 1'b1;
  endtask

  task automatic do_consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat, cb; logic tmo;
    // power-up reset
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if ({rsp_valid, rsp_zero, rsp_result} !== 34'd0) begin errors++; $display("FAIL reset_rsp: valid=%b zero=%b result=%h want all 0", rsp_valid, rsp_zero, rsp_result); end
    checks++; if ({alu_src1, alu_src2, alu_ctrl} !== 68'd0) begin errors++; $display("FAIL reset_alu: src1=%h src2=%h ctrl=%h want 0", alu_src1, alu_src2, alu_ctrl); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // produce a held response (8), then reset asynchronously mid-cycle
    do_issue(4'd2, 32'd5, 32'd3, lat, cb, tmo);
    checks++; if (tmo || rsp_result !== 32'd8) begin errors++; $display("FAIL reset_pre_add: got %h tmo=%b want 8", rsp_result, tmo); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL async_reset_hs: ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin errors++; $display("FAIL async_reset_data: result=%h zero=%b want 0/0", rsp_result, rsp_zero); end
    // async reset in the middle of a multiply
    @(negedge clk); rst = 1'b0;
    @(negedge clk); req_valid = 1'b1; req_op = 4'd15; req_a = 32'd77; req_b = 32'hFFFF;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({alu_src1, alu_src2, alu_ctrl} !== 68'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL async_reset_mul: src1=%h src2=%h ctrl=%h ready=%b want 0/0/0/1", alu_src1, alu_src2, alu_ctrl, req_ready); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_cycle();
    logic [3:0]  t_op [10] = '{4'd2, 4'd6, 4'd10, 4'd10, 4'd9, 4'd8, 4'd7, 4'd12, 4'd3, 4'd13};
    logic [31:0] t_a  [10] = '{32'd5, 32'd7, 32'd7, 32'd7, 32'hABCD, 32'h80000000, 32'd1, 32'd0, 32'hFF, 32'h5};
    logic [31:0] t_b  [10] = '{32'd3, 32'd7, 32'd7, 32'd3, 32'h1234, 32'd4, 32'hFFFFFFFF, 32'd0, 32'hFF, 32'h7};
    logic [31:0] t_r  [10] = '{32'd8, 32'd0, 32'd0, 32'd4, 32'h12340000, 32'h08000000, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic        t_z  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, cb; logic tmo;
    logic [31:0] er; logic ez; logic [3:0] op; logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      do_issue(t_op[i], t_a[i], t_b[i], lat, cb, tmo);
      checks++; if (tmo || lat != 1) begin errors++; $display("FAIL dir_latency[%0d]: got %0d tmo=%b want 1", i, lat, tmo); end
      checks++; if (rsp_result !== t_r[i] || rsp_zero !== t_z[i]) begin errors++; $display("FAIL dir_op%0d[%0d]: got %h/%b want %h/%b", t_op[i], i, rsp_result, rsp_zero, t_r[i], t_z[i]); end
      do_consume();
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL dir_release[%0d]: ready=%b valid=%b want 1/0", i, req_ready, rsp_valid); end
    end
    for (int i = 0; i < 25; i++) begin
      op = 4'($urandom_range(0, 14));
      a = $urandom; b = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 5 == 0) b = a;
      ref_op(op, a, b, er, ez);
      do_issue(op, a, b, lat, cb, tmo);
      checks++; if (tmo || lat != 1 || rsp_result !== er || rsp_zero !== ez) begin errors++; $display("FAIL rnd_op%0d[%0d]: got %h/%b lat=%0d want %h/%b lat=1", op, i, rsp_result, rsp_zero, lat, er, ez); end
      do_consume();
    end
  endtask

  task automatic test_mul();
    logic [31:0] t_a [3] = '{32'd12345, 32'hFFFFFFFF, 32'd0};
    logic [31:0] t_b [3] = '{32'd6789, 32'd2, 32'd9};
    logic [31:0] t_r [3] = '{32'd83810205, 32'hFFFFFFFE, 32'd0};
    logic        t_z [3] = '{1'b0, 1'b0, 1'b1};
    int lat, cb; logic tmo;
    logic [31:0] a, b, er; logic ez;
    for (int i = 0; i < 3; i++) begin
      do_issue(4'd15, t_a[i], t_b[i], lat, cb, tmo);
      checks++; if (tmo || lat != 32) begin errors++; $display("FAIL mul_latency[%0d]: got %0d tmo=%b want 32", i, lat, tmo); end
      checks++; if (cb != 0) begin errors++; $display("FAIL mul_ctrl[%0d]: %0d cycles with ctrl!=2, want 0", i, cb); end
      checks++; if (rsp_result !== t_r[i] || rsp_zero !== t_z[i]) begin errors++; $display("FAIL mul_dir[%0d]: got %h/%b want %h/%b", i, rsp_result, rsp_zero, t_r[i], t_z[i]); end
      do_consume();
    end
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = (i == 0) ? 32'hFFFFFFFF : $urandom;
      ref_op(4'd15, a, b, er, ez);
      do_issue(4'd15, a, b, lat, cb, tmo);
      checks++; if (tmo || lat != 32 || cb != 0 || rsp_result !== er || rsp_zero !== ez) begin errors++; $display("FAIL mul_rnd[%0d]: got %h/%b lat=%0d badctrl=%0d want %h/%b lat=32", i, rsp_result, rsp_zero, lat, cb, er, ez); end
      do_consume();
    end
  endtask

  task automatic test_backpressure();
    int lat, cb; logic tmo;
    int bad_valid, bad_data, bad_ready, bad_alu;
    do_issue(4'd6, 32'd100, 32'd1, lat, cb, tmo);
    checks++; if (tmo || rsp_result !== 32'd99 || rsp_zero !== 1'b0) begin errors++; $display("FAIL bp_first: got %h/%b tmo=%b want 63/0", rsp_result, rsp_zero, tmo); end
    bad_valid = 0; bad_data = 0; bad_ready = 0; bad_alu = 0;
    req_valid = 1'b1; req_op = 4'd2; req_a = 32'd1; req_b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1) bad_valid++;
      if (rsp_result !== 32'd99 || rsp_zero !== 1'b0) bad_data++;
      if (req_ready !== 1'b0) bad_ready++;
      if ({alu_src1, alu_src2, alu_ctrl} !== 68'd0) bad_alu++;
    end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL bp_valid: %0d cycles dropped, want 0", bad_valid); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL bp_data: %0d cycles changed, want 0", bad_data); end
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL bp_req_ready: %0d cycles high, want 0", bad_ready); end
    checks++; if (bad_alu != 0) begin errors++; $display("FAIL bp_alu_idle: %0d cycles nonzero, want 0", bad_alu); end
    req_valid = 1'b0;
    do_consume();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    do_issue(4'd1, 32'hF0, 32'h0F, lat, cb, tmo);
    checks++; if (tmo || lat != 1 || rsp_result !== 32'hFF) begin errors++; $display("FAIL bp_next: got %h lat=%0d want ff lat=1", rsp_result, lat); end
    do_consume();
  endtask

  task automatic test_abort();
    int lat, cb, seen; logic tmo;
    logic [31:0] er; logic ez;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd15; req_a = 32'd1000; req_b = 32'd777;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (alu_ctrl !== 4'd2 || rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_in_mul: ctrl=%h valid=%b want 2/0", alu_ctrl, rsp_valid); end
    #1 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++; if (seen != 0 || req_ready !== 1'b1) begin errors++; $display("FAIL abort_no_rsp: valid cycles=%0d ready=%b want 0/1", seen, req_ready); end
    ref_op(4'd15, 32'hDEADBEEF, 32'h1234, er, ez);
    do_issue(4'd15, 32'hDEADBEEF, 32'h1234, lat, cb, tmo);
    checks++; if (tmo || lat != 32 || rsp_result !== er || rsp_zero !== ez) begin errors++; $display("FAIL abort_next_mul: got %h/%b lat=%0d want %h/%b lat=32", rsp_result, rsp_zero, lat, er, ez); end
    do_consume();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_backpressure();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side initiator for the 32-bit ALU: accepts operation requests over a valid/ready handshake, drives the ALU's `src1`/`src2`/`ctrl` inputs from registered state, and captures `result`/`zero`. Single-cycle ALU codes pass through in one execute cycle. A multicycle multiply is built from 32 repeated ALU ADD operations. Sits between the issue logic of the datapath and one ALU instance, and owns that ALU's inputs exclusively.

## Interface
- `DATA_W`, 32: operand/result width (only 32 supported)
- `MUL_ITER`, 32: multiply iterations (equal to `DATA_W`)
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: asynchronous, active-high reset
- `req_valid_i` in 1: request present
- `req_ready_o` out 1: sequencer can accept a request
- `req_op_i` in 4: operation code (ALU ctrl code, or 15 = MUL)
- `req_a_i` in 32: operand A
- `req_b_i` in 32: operand B
- `alu_src1_o` out 32: to ALU `src1_i`
- `alu_src2_o` out 32: to ALU `src2_i`
- `alu_ctrl_o` out 4: to ALU `ctrl_i`
- `alu_result_i` in 32: from ALU `result_o` (combinational)
- `alu_zero_i` in 1: from ALU `zero_o`
- `rsp_valid_o` out 1: response present
- `rsp_ready_i` in 1: consumer takes response
- `rsp_result_o` out 32: captured result
- `rsp_zero_o` out 1: captured zero flag

## Operation
- ALU code set driven on `alu_ctrl_o`:
  - 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (unsigned), 8 SRL by `src2`
  - 9 LUI (`src2<<16`), 10 BNE (SUB, zero inverted), 12 NOR
  - other codes: ALU returns 0
- States: IDLE, EXEC, MUL, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`&`req_ready_o`: latch op/A/B.
  - op≠15 → EXEC. op=15 → MUL, with acc=0, mcand=A, mplier=B, iteration count=0.
- EXEC (1 cycle):
  - `alu_src1_o`=A, `alu_src2_o`=B, `alu_ctrl_o`=op.
  - Capture `alu_result_i`→`rsp_result_o` and `alu_zero_i`→`rsp_zero_o`, then → RESP.
  - Unsupported codes (3,4,5,11,13,14) are forwarded unchanged. Response is result 0, zero 1.
- MUL (one iteration per cycle):
  - Drive `alu_ctrl_o`=2, `alu_src1_o`=acc, `alu_src2_o`= mplier[0] ? mcand : 0.
  - Update: acc←`alu_result_i`, mcand←mcand<<1, mplier←mplier>>1, count+1.
  - After iteration `MUL_ITER`-1: `rsp_result_o`←final sum (low 32 bits of A·B, unsigned, overflow discarded), `rsp_zero_o`←(final sum==0) → RESP.
  - The ALU's `zero_o` is not used for MUL.
- RESP:
  - `rsp_valid_o`=1; result and zero held stable.
  - On `rsp_ready_i` → IDLE.
- In IDLE and RESP, ALU inputs are driven to 0 (src1=src2=0, ctrl=0).
- `req_*` is ignored outside IDLE.

## Timing
- Reset (async, any state) → IDLE. Outputs after reset:
  - `req_ready_o`=1, `rsp_valid_o`=0, `rsp_result_o`=0, `rsp_zero_o`=0
  - `alu_src1_o`=0, `alu_src2_o`=0, `alu_ctrl_o`=0
- Reset mid-EXEC/MUL/RESP aborts the operation; no response is produced.
- ALU outputs are registered. ALU path is combinational, so the capture happens on the clock edge that ends the state cycle.
- Handshake at edge T:
  - Single-cycle op: EXEC during T..T+1, `rsp_valid_o` high from T+1.
  - MUL: 32 MUL cycles, `rsp_valid_o` high from T+32.
- Response handshake at edge R: `req_ready_o`=1 from R. Minimum spacing is 3 cycles/op (single-cycle), 34 cycles/op (MUL).
- `rsp_valid_o` stays high, with data unchanged, until `rsp_ready_i` is sampled high. Backpressure is unlimited.
- `req_ready_o` is a function of state only; no combinational path from `req_valid_i`.

## Test plan
- Reset values: assert `rst_i` mid-cycle → all outputs take their reset values immediately, without waiting for a clock edge.
- ADD/SUB/BNE:
  - A=5,B=3 op 2 → result 8, zero 0.
  - op 6 A=B=7 → result 0, zero 1.
  - op 10 A=B=7 → result 0, zero 0.
  - op 10 A=7,B=3 → result 4, zero 1.
- LUI/SRL/SLT/NOR:
  - op 9 B=0x1234 → 0x12340000.
  - op 8 A=0x80000000,B=4 → 0x08000000.
  - op 7 A=1,B=0xFFFFFFFF → 1.
  - op 12 A=0,B=0 → 0xFFFFFFFF, zero 0.
- MUL:
  - A=12345,B=6789 → 83810205, response exactly 32 cycles after accept.
  - A=0xFFFFFFFF,B=2 → 0xFFFFFFFE.
  - A=0,B=9 → 0, zero 1.
  - Check that `alu_ctrl_o`=2 on every MUL cycle.
- Backpressure: hold `rsp_ready_i`=0 for 10 cycles → `rsp_valid_o` and data stable, `req_ready_o`=0, a new `req_valid_i` is ignored; release → IDLE next cycle, next request accepted.
- Abort: assert reset during MUL iteration 15 → no response; the next MUL request gives the correct product.
